// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer blocks: fixed-point defaults,
// the element type and the layer sequencer state encoding.
package nn_pkg;

    localparam int FIXED_POINT_LENGTH_DEFAULT   = 16;
    localparam int FIXED_POINT_POSITION_DEFAULT = 10;

    typedef logic signed [FIXED_POINT_LENGTH_DEFAULT-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/latency_tag_pipe.sv
// Shift register carrying a valid flag and a row index alongside the multiplier
// pipeline, so each product arrives together with the neuron it belongs to.
module latency_tag_pipe #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [DEPTH-1:0]  valid_vec_out,
    output logic [ADDR_W-1:0] addr_out
);

    logic [DEPTH-1:0]  valid_r;
    logic [ADDR_W-1:0] addr_r [DEPTH];

    // Advance every tag one stage per clock; reset discards all in-flight tags.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= '0;
            end
        end else begin
            valid_r[0] <= valid_in;
            addr_r[0]  <= addr_in;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                addr_r[i]  <= addr_r[i-1];
            end
        end
    end

    assign valid_vec_out = valid_r;
    assign addr_out      = addr_r[DEPTH-1];

endmodule

// File: rtl/dense_layer_sequencer.sv
// Runs one fully-connected layer: streams weight rows into the shared dot-product
// datapath and writes one (optionally ReLU-clamped) result per neuron.
module dense_layer_sequencer
    import nn_pkg::*;
#(
    parameter int VECTOR_LENGTH        = 16,
    parameter int FIXED_POINT_LENGTH   = FIXED_POINT_LENGTH_DEFAULT,
    parameter int FIXED_POINT_POSITION = FIXED_POINT_POSITION_DEFAULT,
    parameter int NEURON_COUNT         = 16,
    parameter int MULT_LATENCY         = 3,
    parameter int RELU_ENABLE          = 1,
    localparam int VEC_W  = VECTOR_LENGTH * FIXED_POINT_LENGTH,
    localparam int ADDR_W = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          start_in,
    input  logic [VEC_W-1:0]              activation_in,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          weight_rd_en_out,
    output logic [ADDR_W-1:0]             weight_addr_out,
    input  logic [VEC_W-1:0]              weight_data_in,
    output logic [VEC_W-1:0]              mult_vector_1_out,
    output logic [VEC_W-1:0]              mult_vector_2_out,
    input  logic [FIXED_POINT_LENGTH-1:0] mult_product_in,
    output logic                          result_wr_en_out,
    output logic [ADDR_W-1:0]             result_addr_out,
    output logic [FIXED_POINT_LENGTH-1:0] result_data_out
);

    localparam int              TAG_DEPTH = 1 + MULT_LATENCY;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NEURON_COUNT - 1);

    if (NEURON_COUNT < 1 || MULT_LATENCY < 1 || FIXED_POINT_POSITION >= FIXED_POINT_LENGTH) begin : g_param_check
        $error("dense_layer_sequencer: unsupported parameter combination");
    end

    seq_state_e            state_r, state_next_s;
    logic [ADDR_W-1:0]     cnt_r, cnt_next_s;
    logic [VEC_W-1:0]      act_r;
    logic [TAG_DEPTH-1:0]  tag_valid_s;
    logic [ADDR_W-1:0]     tag_addr_s;
    logic                  fetch_s;
    logic                  write_s;
    logic                  drain_empty_s;

    assign fetch_s       = (state_r == FETCH);
    // The final stage is the write in progress; only earlier stages hold pending rows.
    assign drain_empty_s = (tag_valid_s[TAG_DEPTH-2:0] == '0);
    assign write_s       = tag_valid_s[TAG_DEPTH-1] && ((state_r == FETCH) || (state_r == DRAIN));

    // State, row counter and captured activation vector.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            act_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if ((state_r == IDLE) && start_in) begin
                act_r <= activation_in;
            end else begin
                act_r <= act_r;
            end
        end
    end

    // Next-state and row-counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_next_s = '0;
                if (start_in) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                if (cnt_r == LAST_ROW) begin
                    state_next_s = DRAIN;
                end else begin
                    cnt_next_s = cnt_r + ADDR_W'(1'b1);
                end
            end
            DRAIN: begin
                if (drain_empty_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    latency_tag_pipe #(
        .DEPTH  (TAG_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_tag_pipe (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .valid_in      (fetch_s),
        .addr_in       (cnt_r),
        .valid_vec_out (tag_valid_s),
        .addr_out      (tag_addr_s)
    );

    assign busy_out          = (state_r != IDLE);
    assign done_out          = (state_r == DONE);
    assign weight_rd_en_out  = fetch_s;
    assign weight_addr_out   = fetch_s ? cnt_r : '0;
    assign mult_vector_1_out = act_r;
    // Row data is only meaningful the cycle after a read; otherwise present zeros.
    assign mult_vector_2_out = tag_valid_s[0] ? weight_data_in : '0;
    assign result_wr_en_out  = write_s;
    assign result_addr_out   = write_s ? tag_addr_s : '0;

    // Activation function on the returning product.
    always_comb begin
        result_data_out = '0;
        if (!write_s) begin
            result_data_out = '0;
        end else if ((RELU_ENABLE != 0) && mult_product_in[FIXED_POINT_LENGTH-1]) begin
            result_data_out = '0;
        end else begin
            result_data_out = mult_product_in;
        end
    end

endmodule

// File: doc/dense_layer_sequencer.md
Name: dense_layer_sequencer

Overview:
Sequences one fully-connected layer through the shared vector dot-product datapath (vector_multiplier style, fixed pipeline latency). On start it captures the activation vector and streams one weight row per cycle from weight memory into the datapath. It tracks in-flight rows with a tag pipeline, applies optional ReLU and writes one fixed-point result per neuron to the result memory. It sits between the network-level controller and the per-layer multiplier/memories.

Parameters:
VECTOR_LENGTH, 16, elements per activation/weight row
FIXED_POINT_LENGTH, 16, bits per signed fixed-point element
FIXED_POINT_POSITION, 10, fractional bits (1.0 = 0x0400)
NEURON_COUNT, 16, weight rows / results per layer (>=1)
MULT_LATENCY, 3, cycles from operands presented to mult_product_in valid (>=1)
RELU_ENABLE, 1, 1 = clamp negative results to zero

Ports:
clk_in  in  1  single clock, all logic rising-edge
rst_n_in  in  1  asynchronous active-low reset
start_in  in  1  start pulse, accepted only in IDLE
activation_in  in  VECTOR_LENGTH*FIXED_POINT_LENGTH  layer input, captured on accepted start
busy_out  out  1  high from accepted start until done cycle inclusive
done_out  out  1  one-cycle pulse after final result write
weight_rd_en_out  out  1  weight row read strobe
weight_addr_out  out  clog2(NEURON_COUNT)  row index
weight_data_in  in  VECTOR_LENGTH*FIXED_POINT_LENGTH  row data, valid 1 cycle after rd_en
mult_vector_1_out  out  VECTOR_LENGTH*FIXED_POINT_LENGTH  captured activation
mult_vector_2_out  out  VECTOR_LENGTH*FIXED_POINT_LENGTH  weight row (passes weight_data_in)
mult_product_in  in  FIXED_POINT_LENGTH  dot-product result
result_wr_en_out  out  1  result write strobe
result_addr_out  out  clog2(NEURON_COUNT)  neuron index
result_data_out  out  FIXED_POINT_LENGTH  (activated) result

Behaviour:
- Clock and reset: one clock clk_in; reset rst_n_in is asynchronous, active-low. Reset asserted: state IDLE, all counters/tags/activation register cleared, all outputs 0.
- FSM: IDLE -> FETCH on start_in (sampled edge T; activation captured). FETCH: rd_en high cycles T+1..T+NEURON_COUNT, addr 0..NEURON_COUNT-1 ascending; after last issue -> DRAIN. DRAIN: wait until all tags retired -> DONE. DONE: done_out=1 one cycle -> IDLE.
- Tag pipeline: issued row index and valid shifted 1+MULT_LATENCY stages. Operands valid at T+2..T+NEURON_COUNT+1. Result k written at T+2+MULT_LATENCY+k. done_out at T+2+NEURON_COUNT+MULT_LATENCY.
- result_addr_out = tag address; result_data_out = 0 if RELU_ENABLE and mult_product_in[MSB]=1, else mult_product_in unchanged. No saturation; widths fixed at FIXED_POINT_LENGTH.
- result_wr_en_out/addr/data registered only where needed to meet timing above; wr_en never asserted in IDLE or DONE.
- start_in outside IDLE (including the DONE cycle) ignored, no side effects.
- mult_vector_1_out holds captured activation for whole run; changes to activation_in mid-run have no effect.
- Reset mid-operation: immediate return to IDLE, in-flight tags discarded, no further writes, no done pulse.
- NEURON_COUNT=1: a single read, single write, done per formulas.

Decomposition:
- Shared package nn_pkg: FIXED_POINT_LENGTH/POSITION defaults, fixed-point element typedef, sequencer state enum (IDLE, FETCH, DRAIN, DONE).
- Sub-module latency_tag_pipe: parameterised-depth valid+index shift register with async active-low clear.

Test Plan:
(Bench uses behavioural dot-product model with MULT_LATENCY=3, NEURON_COUNT=4.)
- Activations all 0x0400, row n elements all (n+1)*0x0040, start at T=0 -> writes at cycles 5,6,7,8, addr 0..3, data 0x0400,0x0800,0x0C00,0x1000; done pulse at cycle 9 only; busy high 1..9.
- Row 2 weights 0xFF80 (-0.125) x 1.0 -> dot 0xF800; RELU_ENABLE=1 writes 0x0000 at addr 2, RELU_ENABLE=0 writes 0xF800.
- start_in pulsed at cycles 3 and 9 during run -> ignored; exactly 4 writes, one done; start at cycle 10 starts a new run.
- activation_in changed at cycle 2 -> results unchanged vs first scenario.
- rst_n_in low at cycle 6 for one cycle -> all outputs 0 immediately, no writes after, no done; subsequent start yields full correct run.
- NEURON_COUNT=1, start T=0 -> single read at 1, write at 5 addr 0, done at 6.
